// File: rtl/scan_select_sequencer_pkg.sv
// scan_seq_pkg: shared state encoding and width constants for the scan select sequencer
package scan_seq_pkg;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;
endpackage

// File: rtl/scan_select_sequencer_if.sv
// scan_select_sequencer_if: control/status bundle between a sweep requester and the sequencer
//   master: drives start, stop, first, last, continuous (and skip_mask when SCAN_SKIP_MASK_EN)
//   slave : drives select, enable, busy, done
interface scan_select_sequencer_if;
  import scan_seq_pkg::*;
  logic start;
  logic stop;
  logic continuous;
  logic [CODE_W-1:0] first;
  logic [CODE_W-1:0] last;
  logic [CODE_W-1:0] select;
  logic enable;
  logic busy;
  logic done;
`ifdef SCAN_SKIP_MASK_EN
  logic [2**CODE_W-1:0] skip_mask;
  modport master (output start, stop, first, last, continuous, skip_mask, input select, enable, busy, done);
  modport slave (input start, stop, first, last, continuous, skip_mask, output select, enable, busy, done);
`else
  modport master (output start, stop, first, last, continuous, input select, enable, busy, done);
  modport slave (input start, stop, first, last, continuous, output select, enable, busy, done);
`endif
endinterface

// File: rtl/scan_select_sequencer_dwell_counter.sv
// dwell_counter: loadable down-counter with zero flag timing each code's dwell
//   clk, reset (async, active-high); load/value: preset; dec: count down; zero: count is 0
module dwell_counter
  import scan_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= value;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: sweeps a 4-bit decoder select from first to last with dwell and guard cycles
//   clk, reset (async, active-high), bus: scan_select_sequencer_if.slave
//   Optional macro SCAN_SKIP_MASK_EN adds bus.skip_mask; masked codes take one enable-low cycle.
module scan_select_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  scan_select_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  state_t state, nxt_state;
  logic [CODE_W-1:0] select_q, nxt_select, first_q, last_q, adv;
  logic cont_q, done_q, nxt_done, latch, load, dec, zero, skip_first, skip_adv;
  assign adv = (select_q == last_q) ? first_q : select_q + 1'b1;
`ifdef SCAN_SKIP_MASK_EN
  assign skip_first = bus.skip_mask[bus.first];
  assign skip_adv   = bus.skip_mask[adv];
`else
  assign skip_first = 1'b0;
  assign skip_adv   = 1'b0;
`endif
  dwell_counter u_dwell (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .dec   (dec),
    .value (DWELL_LOAD),
    .zero  (zero)
  );
  always_comb begin
    nxt_state  = state;
    nxt_select = select_q;
    nxt_done   = 1'b0;
    latch      = 1'b0;
    load       = 1'b0;
    dec        = 1'b0;
    if (bus.stop) nxt_state = IDLE;
    else
      case (state)
        IDLE:
          if (bus.start) begin
            latch      = 1'b1;
            load       = 1'b1;
            nxt_select = bus.first;
            nxt_state  = skip_first ? GUARD : ACTIVE;
          end
        ACTIVE: begin
          dec       = !zero;
          nxt_state = zero ? GUARD : ACTIVE;
        end
        GUARD:
          if (select_q == last_q && !cont_q) begin
            nxt_state = IDLE;
            nxt_done  = 1'b1;
          end else begin
            load       = 1'b1;
            nxt_select = adv;
            nxt_state  = skip_adv ? GUARD : ACTIVE;
          end
        default: nxt_state = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      select_q <= '0;
      first_q  <= '0;
      last_q   <= '0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= nxt_state;
      select_q <= nxt_select;
      done_q   <= nxt_done;
      if (latch) begin
        first_q <= bus.first;
        last_q  <= bus.last;
        cont_q  <= bus.continuous;
      end
    end
  assign bus.select = select_q;
  assign bus.enable = state == ACTIVE;
  assign bus.busy   = state != IDLE;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_scan_select_sequencer.sv
// tb_scan_select_sequencer: scoreboard bench for scan_select_sequencer with DWELL_CYCLES=2
module tb_scan_select_sequencer;
  localparam int DW = 2;
  typedef struct {
    bit         is_done;
    logic [3:0] code;
    int         len;
    int         gap;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int bursts_seen = 0;
  exp_t q[$];
  scan_select_sequencer_if bus ();
  scan_select_sequencer #(.DWELL_CYCLES(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [3:0] code, input int gap);
    exp_t e;
    e.is_done = 1'b0; e.code = code; e.len = DW; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.code = 4'h0; e.len = 0; e.gap = 1;
    q.push_back(e);
  endtask

  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input logic c, input bit chk_en);
    bus.first = f; bus.last = l; bus.continuous = c;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (chk_en) check("latency", {10'h0, bus.enable, bus.busy, bus.select}, {10'h0, 2'b11, f});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL %s: timeout busy=%b expected 0", name, bus.busy);
  endtask

  task automatic wait_bursts(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bursts_seen >= n) return;
    end
    checks++; errors++;
    $display("FAIL wait_bursts: seen %0d expected %0d", bursts_seen, n);
  endtask

  // Monitor: rebuilds enable bursts and done pulses, then compares them against the queue.
  int run = 0, low = 0, gap_seen = 0;
  logic [3:0] code_seen;
  bit stable;
  always @(negedge clk) begin
    if (reset) begin
      run = 0; low = 0;
    end else if (bus.enable) begin
      if (run == 0) begin
        code_seen = bus.select; gap_seen = low; stable = 1'b1;
      end else if (bus.select !== code_seen) stable = 1'b0;
      run++;
    end else begin
      if (run > 0) begin
        exp_t e;
        checks++;
        bursts_seen++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL burst: got code %h len %0d, expected nothing", code_seen, run);
        end else begin
          e = q.pop_front();
          if (e.is_done || e.code !== code_seen || e.len != run || e.gap != gap_seen || !stable) begin
            errors++;
            $display("FAIL burst: got code %h len %0d gap %0d stable %b, expected done %b code %h len %0d gap %0d",
                     code_seen, run, gap_seen, stable, e.is_done, e.code, e.len, e.gap);
          end
        end
        run = 0; low = 0;
      end
      if (bus.done) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done: got pulse, expected nothing");
        end else begin
          e = q.pop_front();
          if (!e.is_done || low != e.gap || bus.busy) begin
            errors++;
            $display("FAIL done: got gap %0d busy %b, expected done %b gap %0d busy 0",
                     low, bus.busy, e.is_done, e.gap);
          end
        end
        low = 0;
      end else if (bus.busy) low++;
      else low = 0;
    end
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.first = 4'h0; bus.last = 4'h0; bus.continuous = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
    bus.skip_mask = 16'h0;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_state", {9'h0, bus.select, bus.enable, bus.busy, bus.done}, 16'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("no_auto_start", {14'h0, bus.busy, bus.enable}, 16'h0);
    push_burst(4'd3, 0); push_burst(4'd4, 1); push_burst(4'd5, 1); push_done();
    run_sweep(4'd3, 4'd5, 1'b0, 1'b1);
    wait_idle("sweep_3_5");
    push_burst(4'd14, 0); push_burst(4'd15, 1); push_burst(4'd0, 1); push_burst(4'd1, 1); push_done();
    run_sweep(4'd14, 4'd1, 1'b0, 1'b1);
    wait_idle("sweep_wrap");
    push_burst(4'd3, 0); push_burst(4'd4, 1); push_burst(4'd5, 1); push_done();
    run_sweep(4'd3, 4'd5, 1'b0, 1'b1);
    @(posedge clk); #1 bus.first = 4'd9; bus.last = 4'd12; bus.continuous = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle("busy_start_ignored");
    push_burst(4'd7, 0); push_burst(4'd7, 1); push_burst(4'd7, 1);
    run_sweep(4'd7, 4'd7, 1'b1, 1'b1);
    wait_bursts(bursts_seen + 3);
    bus.stop = 1'b1;
    @(posedge clk); #1 check("stop", {13'h0, bus.enable, bus.busy, bus.done}, 16'h0);
    bus.stop = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("stop_stays_idle", {14'h0, bus.enable, bus.busy}, 16'h0);
    bus.first = 4'd2; bus.last = 4'd3; bus.continuous = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_same", {14'h0, bus.enable, bus.busy}, 16'h0);
    repeat (3) @(posedge clk);
    #1 check("start_stop_idle", {14'h0, bus.enable, bus.busy}, 16'h0);
    run_sweep(4'd9, 4'd9, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset", {9'h0, bus.select, bus.enable, bus.busy, bus.done}, 16'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("post_reset_idle", {14'h0, bus.enable, bus.busy}, 16'h0);
`ifdef SCAN_SKIP_MASK_EN
    bus.skip_mask = 16'h0010;
    push_burst(4'd3, 0); push_burst(4'd5, 2); push_done();
    run_sweep(4'd3, 4'd5, 1'b0, 1'b1);
    wait_idle("skip_mask");
    bus.skip_mask = 16'h0;
`endif
    repeat (3) @(posedge clk);
    #1 check("queue_empty", 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
